waveform_sequencer: RTL and testbench

- Consumer of the waveform clock pulse. On every waveform clock pulse it reads the next sample of a stored waveform from sample RAM and presents it to the DAC interface.
- Steps through a programmable address window (start address, length).
- Supports continuous playback or a burst of N complete waveform periods.
- Sits between the waveform clock generator, the sample RAM read port and the DAC driver. One instance per output channel.

---
 rtl/waveform_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_waveform_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_sequencer.sv
// Waveform sequencer: on each waveform clock pulse, read the next sample from
// a programmable address window of sample RAM and present it to the DAC.
// Plays continuously or for a burst of complete waveform periods. The RAM
// read latency is a parameter; the read pipeline accepts one pulse per cycle.
module waveform_sequencer #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 14,
    parameter int CNT_WIDTH   = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  ws_en_i,
    input  logic                  ws_mode_i,
    input  logic [ADDR_WIDTH-1:0] ws_start_addr_i,
    input  logic [ADDR_WIDTH-1:0] ws_len_i,
    input  logic [CNT_WIDTH-1:0]  ws_burst_i,
    input  logic                  wc_clk_p_i,
    output logic                  ram_rd_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] dac_data_o,
    output logic                  dac_valid_o,
    output logic                  ws_busy_o,
    output logic                  ws_done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_DRAIN    = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_DIS = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Configuration latched when playback starts
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  burst_q, burst_d;

    // Playback position
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic                  burst_end_q, burst_end_d;

    // Read request and read pipeline
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RAM_LATENCY-1:0] pipe_q, pipe_d;

    // DAC output registers
    logic [DATA_WIDTH-1:0] dac_q, dac_d;
    logic                  valid_q, valid_d;

    logic                  last_sample;
    logic [CNT_WIDTH-1:0]  period_inc;
    logic                  inflight;

    assign last_sample = (idx_q == (len_q - 1'b1));
    assign period_inc  = period_q + 1'b1;
    // A read is outstanding from the cycle it is issued until its data lands
    assign inflight    = rd_q | (|pipe_q);

    // State register
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus configuration, position and read-request updates
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        len_d       = len_q;
        mode_d      = mode_q;
        burst_d     = burst_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        period_d    = period_q;
        burst_end_d = burst_end_q;
        rd_d        = 1'b0;
        addr_d      = addr_q;

        case (state_q)
            S_IDLE: begin
                if (ws_en_i && (ws_len_i != '0)) begin
                    state_d     = S_RUN;
                    start_d     = ws_start_addr_i;
                    len_d       = ws_len_i;
                    mode_d      = ws_mode_i;
                    // A burst count of zero plays a single period
                    burst_d     = (ws_burst_i == '0) ? CNT_WIDTH'(1) : ws_burst_i;
                    ptr_d       = ws_start_addr_i;
                    idx_d       = '0;
                    period_d    = '0;
                    burst_end_d = 1'b0;
                end
            end

            S_RUN: begin
                // Disable wins over a pulse arriving in the same cycle
                if (!ws_en_i) begin
                    state_d = S_DRAIN;
                end else if (wc_clk_p_i) begin
                    rd_d   = 1'b1;
                    addr_d = ptr_q;
                    if (last_sample) begin
                        idx_d    = '0;
                        ptr_d    = start_q;
                        period_d = period_inc;
                        if (mode_q && (period_inc == burst_q)) begin
                            state_d     = S_DRAIN;
                            burst_end_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (!inflight) begin
                    state_d = burst_end_q ? S_DONE : S_IDLE;
                end
            end

            S_DONE: begin
                state_d = S_WAIT_DIS;
            end

            S_WAIT_DIS: begin
                if (!ws_en_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read pipeline: one flag per cycle of RAM latency
    genvar gi;
    generate
        for (gi = 0; gi < RAM_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                assign pipe_d[gi] = rd_q;
            end else begin : g_next
                assign pipe_d[gi] = pipe_q[gi-1];
            end
        end
    endgenerate

    // DAC update when the oldest read's data is present on ram_data_i
    always_comb begin
        valid_d = pipe_q[RAM_LATENCY-1];
        dac_d   = dac_q;
        if (pipe_q[RAM_LATENCY-1]) begin
            dac_d = ram_data_i;
        end
    end

    // Datapath registers; reset discards all in-flight reads
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            start_q     <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            burst_q     <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            period_q    <= '0;
            burst_end_q <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            pipe_q      <= '0;
            dac_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            start_q     <= start_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            burst_q     <= burst_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            period_q    <= period_d;
            burst_end_q <= burst_end_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            pipe_q      <= pipe_d;
            dac_q       <= dac_d;
            valid_q     <= valid_d;
        end
    end

    assign ram_rd_o    = rd_q;
    assign ram_addr_o  = addr_q;
    assign dac_data_o  = dac_q;
    assign dac_valid_o = valid_q;
    assign ws_busy_o   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign ws_done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed testbench for waveform_sequencer: one instance with RAM latency 1
// and one with RAM latency 3, each fed by a small sample RAM where RAM[a] = a.
module tb_waveform_sequencer;

    localparam int AW = 12;
    localparam int DW = 14;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] start = '0;
    logic [AW-1:0] len = '0;
    logic [CW-1:0] burst = '0;
    logic          wc = 1'b0;

    logic          rd1, valid1, busy1, done1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] rdata1, dac1;
    logic          rd3, valid3, busy3, done3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] dac3;
    logic [DW-1:0] r3 [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    waveform_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .RAM_LATENCY(1)) u_dut1 (
        .sys_clk_i(clk), .sys_rst_i(rst), .ws_en_i(en), .ws_mode_i(mode),
        .ws_start_addr_i(start), .ws_len_i(len), .ws_burst_i(burst), .wc_clk_p_i(wc),
        .ram_rd_o(rd1), .ram_addr_o(addr1), .ram_data_i(rdata1),
        .dac_data_o(dac1), .dac_valid_o(valid1), .ws_busy_o(busy1), .ws_done_o(done1)
    );

    waveform_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .RAM_LATENCY(3)) u_dut3 (
        .sys_clk_i(clk), .sys_rst_i(rst), .ws_en_i(en), .ws_mode_i(mode),
        .ws_start_addr_i(start), .ws_len_i(len), .ws_burst_i(burst), .wc_clk_p_i(wc),
        .ram_rd_o(rd3), .ram_addr_o(addr3), .ram_data_i(r3[2]),
        .dac_data_o(dac3), .dac_valid_o(valid3), .ws_busy_o(busy3), .ws_done_o(done3)
    );

    // Sample RAM models: contents RAM[a] = a, captured on the read strobe
    always @(posedge clk) begin
        if (rd1) rdata1 <= DW'(addr1);
        if (rd3) r3[0] <= DW'(addr3);
        r3[1] <= r3[0];
        r3[2] <= r3[1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [AW-1:0] wexp [5];

    initial begin
        wexp[0] = 12'hFFE; wexp[1] = 12'hFFF; wexp[2] = 12'h000;
        wexp[3] = 12'h001; wexp[4] = 12'hFFE;

        // Reset: every output zero
        step(); step();
        check("rst rd", 32'(rd1), 32'(0));
        check("rst addr", 32'(addr1), 32'(0));
        check("rst dac", 32'(dac1), 32'(0));
        check("rst valid", 32'(valid1), 32'(0));
        check("rst busy", 32'(busy1), 32'(0));
        check("rst done", 32'(done1), 32'(0));
        rst = 1'b0;

        // Continuous, start 0x010, len 4, one pulse every 5 cycles
        start = 12'h010; len = 12'd4; mode = 1'b0; burst = 16'd0; en = 1'b1;
        step();
        check("cont busy", 32'(busy1), 32'(1));
        for (int i = 0; i < 6; i++) begin
            wc = 1'b1;
            step();
            wc = 1'b0;
            check($sformatf("cont rd p%0d", i), 32'(rd1), 32'(1));
            check($sformatf("cont addr p%0d", i), 32'(addr1), 32'(12'h010 + (i % 4)));
            step();
            check($sformatf("cont rd_low p%0d", i), 32'(rd1), 32'(0));
            check($sformatf("cont addr_hold p%0d", i), 32'(addr1), 32'(12'h010 + (i % 4)));
            check($sformatf("cont early_valid p%0d", i), 32'(valid1), 32'(0));
            step();
            check($sformatf("cont valid p%0d", i), 32'(valid1), 32'(1));
            check($sformatf("cont dac p%0d", i), 32'(dac1), 32'(12'h010 + (i % 4)));
            step();
            check($sformatf("cont valid_low p%0d", i), 32'(valid1), 32'(0));
            check($sformatf("cont dac_hold p%0d", i), 32'(dac1), 32'(12'h010 + (i % 4)));
            step();
        end
        en = 1'b0;
        step();
        check("cont drain busy", 32'(busy1), 32'(1));
        step();
        check("cont idle busy", 32'(busy1), 32'(0));
        check("cont done", 32'(done1), 32'(0));

        // Burst: len 3, 2 periods, pulse every cycle for 8 cycles
        start = 12'h020; len = 12'd3; mode = 1'b1; burst = 16'd2; en = 1'b1;
        step();
        wc = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 8) wc = 1'b0;
            check($sformatf("burst rd c%0d", c), 32'(rd1), 32'(c <= 6));
            if (c <= 6)
                check($sformatf("burst addr c%0d", c), 32'(addr1), 32'(12'h020 + ((c - 1) % 3)));
            check($sformatf("burst valid c%0d", c), 32'(valid1), 32'(c >= 3 && c <= 8));
            if (c >= 3 && c <= 8)
                check($sformatf("burst dac c%0d", c), 32'(dac1), 32'(12'h020 + ((c - 3) % 3)));
            check($sformatf("burst done c%0d", c), 32'(done1), 32'(c == 9));
            check($sformatf("burst busy c%0d", c), 32'(busy1), 32'(c <= 8));
        end
        wc = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("waitdis rd c%0d", c), 32'(rd1), 32'(0));
            check($sformatf("waitdis busy c%0d", c), 32'(busy1), 32'(0));
        end
        wc = 1'b0;
        en = 1'b0;
        step(); step();
        check("burst idle busy", 32'(busy1), 32'(0));
        check("burst idle done", 32'(done1), 32'(0));

        // Address wrap: start 0xFFE, len 4, five back-to-back pulses
        start = 12'hFFE; len = 12'd4; mode = 1'b0; en = 1'b1;
        step();
        wc = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 5) begin
                wc = 1'b0;
                en = 1'b0;
            end
            check($sformatf("wrap rd c%0d", c), 32'(rd1), 32'(c <= 5));
            if (c <= 5)
                check($sformatf("wrap addr c%0d", c), 32'(addr1), 32'(wexp[c-1]));
            check($sformatf("wrap valid c%0d", c), 32'(valid1), 32'(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7)
                check($sformatf("wrap dac c%0d", c), 32'(dac1), 32'(wexp[c-3]));
            check($sformatf("wrap busy c%0d", c), 32'(busy1), 32'(c <= 7));
        end

        // Enable dropped during the third of three back-to-back pulses
        start = 12'h030; len = 12'd8; mode = 1'b0; en = 1'b1;
        step();
        wc = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 2) en = 1'b0;
            if (c == 3) wc = 1'b0;
            check($sformatf("endrop rd c%0d", c), 32'(rd1), 32'(c <= 2));
            if (c <= 2)
                check($sformatf("endrop addr c%0d", c), 32'(addr1), 32'(12'h030 + c - 1));
            check($sformatf("endrop valid c%0d", c), 32'(valid1), 32'(c == 3 || c == 4));
            if (c == 3 || c == 4)
                check($sformatf("endrop dac c%0d", c), 32'(dac1), 32'(12'h030 + c - 3));
            check($sformatf("endrop busy c%0d", c), 32'(busy1), 32'(c <= 4));
            check($sformatf("endrop done c%0d", c), 32'(done1), 32'(0));
        end

        // Reset one cycle after a read strobe
        start = 12'h040; len = 12'd4; en = 1'b1;
        step();
        wc = 1'b1;
        step();
        wc = 1'b0;
        check("midrst rd before", 32'(rd1), 32'(1));
        check("midrst addr before", 32'(addr1), 32'(12'h040));
        rst = 1'b1;
        step();
        check("midrst rd", 32'(rd1), 32'(0));
        check("midrst addr", 32'(addr1), 32'(0));
        check("midrst dac", 32'(dac1), 32'(0));
        check("midrst valid", 32'(valid1), 32'(0));
        check("midrst busy", 32'(busy1), 32'(0));
        check("midrst done", 32'(done1), 32'(0));
        rst = 1'b0;
        en = 1'b0;
        step();
        check("midrst no_valid1", 32'(valid1), 32'(0));
        step();
        check("midrst no_valid2", 32'(valid1), 32'(0));

        // Zero length: stays idle
        len = 12'd0; en = 1'b1; wc = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("len0 busy c%0d", c), 32'(busy1), 32'(0));
            check($sformatf("len0 rd c%0d", c), 32'(rd1), 32'(0));
        end
        wc = 1'b0;
        en = 1'b0;
        step();

        // RAM latency 3: valid five cycles after the pulse
        start = 12'h050; len = 12'd4; mode = 1'b0; en = 1'b1;
        step();
        wc = 1'b1;
        step();
        wc = 1'b0;
        check("lat3 rd", 32'(rd3), 32'(1));
        check("lat3 addr", 32'(addr3), 32'(12'h050));
        for (int c = 2; c <= 6; c++) begin
            step();
            check($sformatf("lat3 valid c%0d", c), 32'(valid3), 32'(c == 5));
            if (c == 5)
                check("lat3 dac", 32'(dac3), 32'(12'h050));
            check($sformatf("lat1 valid c%0d", c), 32'(valid1), 32'(c == 3));
        end
        en = 1'b0;
        step(); step(); step();
        check("lat3 idle busy", 32'(busy3), 32'(0));
        check("lat3 done", 32'(done3), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
